mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer in front of the 128-word data memory. Port 0 is instruction fetch and port 1 is load/store. The block serialises their requests with round-robin arbitration and drives the memory's `mem_write` / `m_addr` / `m_w_data` controls, timed to the memory's posedge-registered read and negedge write. It returns read data or a write acknowledge to the granted requester.

## Interface
- `DATA_W`, 32: data width.
- `DEPTH`, 128: memory words. Addresses at or above `DEPTH` are out of range.
- `clk` input 1: single clock. All state is updated on posedge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `p0_valid`, `p1_valid` input 1: request present on that port.
- `p0_ready`, `p1_ready` output 1: grant. A request transfers when valid and ready are both 1 on a posedge.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` input 32: word address.
- `p0_wdata`, `p1_wdata` input DATA_W: write data.
- `p0_resp_valid`, `p1_resp_valid` output 1: one-cycle response pulse.
- `p0_resp_rdata`, `p1_resp_rdata` output DATA_W: read data. It is 0 for writes and errors.
- `p0_resp_err`, `p1_resp_err` output 1: address out of range. Qualified by `resp_valid`.
- `mem_write` output 1: memory write enable.
- `m_addr` output 32: memory word address.
- `m_w_data` output DATA_W: memory write data.
- `m_r_data` input DATA_W: memory read data. It reflects `m_addr` as sampled at the previous posedge.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. Each access occupies exactly 3 cycles, so peak throughput is 1 request per 3 cycles.
- **IDLE**
  - `ready` is 1 only for the winning valid port. The ready output is combinational from the valid inputs and the priority pointer.
  - On handshake the block latches into `cmd_*` registers: owner, we, addr, wdata, and err. `err` = (addr ≥ DEPTH).
- **ACCESS**
  - `m_addr` = `cmd_addr` and `m_w_data` = `cmd_wdata`.
  - `mem_write` = `cmd_we & ~cmd_err`, so the write lands on this cycle's negedge.
  - For a read, the memory samples `m_addr` at the posedge that ends ACCESS.
  - When `cmd_err` = 1, `m_addr` is forced to 0.
- **RESP**
  - The owner's `resp_valid` = 1.
  - `resp_rdata` = `m_r_data` for a good read, otherwise 0.
  - `resp_err` = `cmd_err`.
  - Both ports' `ready` = 0 in ACCESS and in RESP.
- **Arbitration**
  - Two-way round-robin. After reset, port 0 holds priority.
  - After each grant, priority moves to the other port.
  - A lone valid port is granted regardless of priority.
- `p*_valid` may drop without a handshake; no state changes result. The request fields are sampled only at handshake and may change afterwards.
- `mem_write` is 0 outside ACCESS.
- `m_addr` and `m_w_data` hold the `cmd_*` values outside ACCESS. They are don't-care there, but they must not glitch while `mem_write` = 1.
- **Reset** (asynchronous, `rst` = 0; this also applies mid-operation):
  - State returns to IDLE and priority to port 0. `cmd_*` registers clear to 0.
  - `mem_write`, `ready`, `resp_valid` and `resp_err` are all 0 immediately. `m_addr`, `m_w_data` and `resp_rdata` read 0.
  - An in-flight request is dropped with no response, and the requester must reissue it.
  - The memory's own clear is driven separately by the top level.

## Timing
- Handshake at the posedge ending cycle N.
- `mem_write` is high during cycle N+1, and the write takes effect at the N+1 negedge.
- `resp_valid` is high during cycle N+2, and the next grant is possible in cycle N+3.
- Read-after-write from either port returns the new data, because the write lands in cycle N+1 of an earlier access.
- Simultaneous valid on both ports in IDLE: exactly one ready is asserted, never both.

## Structure
- Shared header `mem_arb_defs.vh` holds:
  - state encodings `ST_IDLE` = 2'd0, `ST_ACCESS` = 2'd1, `ST_RESP` = 2'd2;
  - port indices `PORT_IF` = 0, `PORT_LS` = 1;
  - the `DEPTH` default.
- One sub-module, `rr_arb2`: valid[1:0] in, grant[1:0] out, with its own priority flop that advances on an accept strobe.

## Test plan
- **Single read:** reset; preload mem[5] = 32'hDEADBEEF; p0 reads addr 5 → `p0_ready` in cycle 0, `mem_write` = 0, `p0_resp_valid` in cycle 2 with rdata 32'hDEADBEEF.
- **Write then read:** p1 writes 32'h12345678 to addr 127 → `mem_write` = 1 only in cycle 1 and the ack carries rdata 0; then p0 reads addr 127 and gets 32'h12345678.
- **Contention:** both ports hold valid continuously for 4 requests → grants alternate p0, p1, p0, p1, spaced 3 cycles apart.
- **Out of range:** p1 writes to addr 128 → `mem_write` stays 0, `p1_resp_err` = 1, rdata = 0; mem[0] is unchanged.
- **Reset mid-operation:** assert `rst` = 0 during ACCESS of a write → `mem_write` drops immediately with no response; after release, port 0 holds priority and the target word is either unchanged or, if the negedge was already reached, written.
- **Lone requester:** p1 alone valid right after reset → granted despite port 0 holding priority; the next tie then goes to p0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_DATA_W    = 32;
  localparam int DEFAULT_DEPTH = 128;
  localparam int ADDR_W        = 32;

  // Requester indices: instruction fetch and load/store.
  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Word addresses at or above the memory depth are out of range.
  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth);
    return addr >= ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the memory control bus. The arbiter uses the
// slave view; requesters and the memory model sit on the master view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
  ();

  logic                  p0_valid;
  logic                  p0_ready;
  logic                  p0_we;
  logic [ADDR_W-1:0]     p0_addr;
  logic [MEM_DATA_W-1:0] p0_wdata;
  logic                  p0_resp_valid;
  logic [MEM_DATA_W-1:0] p0_resp_rdata;
  logic                  p0_resp_err;

  logic                  p1_valid;
  logic                  p1_ready;
  logic                  p1_we;
  logic [ADDR_W-1:0]     p1_addr;
  logic [MEM_DATA_W-1:0] p1_wdata;
  logic                  p1_resp_valid;
  logic [MEM_DATA_W-1:0] p1_resp_rdata;
  logic                  p1_resp_err;

  logic                  mem_write;
  logic [ADDR_W-1:0]     m_addr;
  logic [MEM_DATA_W-1:0] m_w_data;
  logic [MEM_DATA_W-1:0] m_r_data;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    output mem_write, m_addr, m_w_data,
    input  m_r_data
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    input  mem_write, m_addr, m_w_data,
    output m_r_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A tie goes to the port holding priority; after
// an accepted grant, priority passes to the port that was not granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio_q;
  logic prio_d;

  // Winner selection and priority hand-over.
  always_comb begin
    grant  = valid;
    prio_d = prio_q;
    if (valid == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
    if (accept) begin
      // Port 0 won -> port 1 gets priority, and vice versa.
      prio_d = grant[0];
    end
  end

  // Priority flop; port 0 owns priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto the data memory.
// Each access is IDLE (grant) -> ACCESS (drive memory) -> RESP (answer).
//
//   state  | meaning
//   IDLE   | waiting for a request; ready offered to the arbitration winner
//   ACCESS | memory driven from cmd registers; write lands on this negedge
//   RESP   | one-cycle response to the owner; read data taken from memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e        state_q;
  logic              cmd_owner_q;
  logic              cmd_we_q;
  logic              cmd_err_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              mem_write_q;
  logic [1:0]        resp_valid_q;
  logic [1:0]        resp_err_q;

  logic              idle;
  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              handshake;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_err;
  logic              good_read;

  assign idle      = (state_q == ST_IDLE);
  assign req_valid = {bus.p1_valid, bus.p0_valid} & {2{idle}};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (handshake),
    .grant  (grant)
  );

  // Ready must read 0 the instant reset asserts, not only after the next edge.
  assign ready     = grant & {2{rst}};
  assign handshake = |ready;

  // Request fields from whichever port wins this cycle.
  always_comb begin
    req_we    = bus.p0_we;
    req_addr  = bus.p0_addr;
    req_wdata = bus.p0_wdata;
    if (grant[PORT_LS]) begin
      req_we    = bus.p1_we;
      req_addr  = bus.p1_addr;
      req_wdata = bus.p1_wdata;
    end
  end

  assign req_err = addr_oob(req_addr, DEPTH);

  // Access sequencer: latch on handshake, drive memory, then respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cmd_owner_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_err_q   <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            state_q     <= ST_ACCESS;
            cmd_owner_q <= grant[PORT_LS];
            cmd_we_q    <= req_we;
            cmd_err_q   <= req_err;
            cmd_addr_q  <= req_addr;
            cmd_wdata_q <= req_wdata;
            // Registered so the enable is clean for the whole ACCESS cycle.
            mem_write_q <= req_we & ~req_err;
          end
        end
        ST_ACCESS: begin
          state_q      <= ST_RESP;
          mem_write_q  <= 1'b0;
          resp_valid_q <= cmd_owner_q ? 2'b10 : 2'b01;
          resp_err_q   <= cmd_owner_q ? {cmd_err_q, 1'b0} : {1'b0, cmd_err_q};
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 2'b00;
          resp_err_q   <= 2'b00;
        end
        default: begin
          state_q      <= ST_IDLE;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 2'b00;
          resp_err_q   <= 2'b00;
        end
      endcase
    end
  end

  // Memory side. Out-of-range commands present address 0 so the memory never
  // sees an index it cannot decode; both sources are flops stable in ACCESS.
  assign bus.mem_write = mem_write_q;
  assign bus.m_addr    = cmd_err_q ? '0 : cmd_addr_q;
  assign bus.m_w_data  = cmd_wdata_q;

  // Memory read data is valid in RESP because it sampled m_addr at the edge
  // that closed ACCESS.
  assign good_read = (state_q == ST_RESP) & ~cmd_we_q & ~cmd_err_q;

  assign bus.p0_ready      = ready[PORT_IF];
  assign bus.p1_ready      = ready[PORT_LS];
  assign bus.p0_resp_valid = resp_valid_q[PORT_IF];
  assign bus.p1_resp_valid = resp_valid_q[PORT_LS];
  assign bus.p0_resp_err   = resp_err_q[PORT_IF];
  assign bus.p1_resp_err   = resp_err_q[PORT_LS];
  assign bus.p0_resp_rdata = (good_read && !cmd_owner_q) ? bus.m_r_data : '0;
  assign bus.p1_resp_rdata = (good_read &&  cmd_owner_q) ? bus.m_r_data : '0;

  // Structural invariants of the sequencer.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    !(bus.p0_ready && bus.p1_ready));
  a_write_only_in_access: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_write |-> (state_q == ST_ACCESS));
  a_no_ready_when_busy: assert property (@(posedge clk) disable iff (!rst)
    (state_q != ST_IDLE) |-> !(bus.p0_ready || bus.p1_ready));
  a_resp_only_in_resp: assert property (@(posedge clk) disable iff (!rst)
    (|resp_valid_q) |-> (state_q == ST_RESP));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of memory contents and priority.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory model: posedge-registered read, negedge write.
  logic [31:0] mem [0:127];
  logic        mem_clr = 1'b0;
  logic        pre_en  = 1'b0;
  logic [6:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.mem_write && bus.m_addr < 32'd128) begin
      mem[bus.m_addr[6:0]] <= bus.m_w_data;
    end
  end

  always @(posedge clk) begin
    bus.m_r_data <= (bus.m_addr < 32'd128) ? mem[bus.m_addr[6:0]] : 32'hBAD0_BAD0;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:127];
  int          ref_prio;
  int          checks   = 0;
  int          failures = 0;

  typedef struct packed {
    int          gnt;
    int          wait_cyc;
    logic        both_ready;
    logic        mw1;
    logic        mw2;
    logic        busy_ready;
    logic        rv_early;
    logic        rv_other;
    logic        rv;
    logic        err;
    logic [31:0] maddr1;
    logic [31:0] mwdata1;
    logic [31:0] rdata;
  } obs_t;

  function automatic int exp_gnt(input logic [1:0] vm);
    if (vm == 2'b11) return ref_prio;
    return vm[1] ? 1 : 0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic we, input logic [31:0] a);
    if (!we && a < 32'd128) return ref_mem[a[6:0]];
    return 32'h0;
  endfunction

  task automatic model_commit(input int g, input logic we, input logic [31:0] a,
                              input logic [31:0] d);
    ref_prio = 1 - g;
    if (we && a < 32'd128) ref_mem[a[6:0]] = d;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pre_idx = 7'(idx);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Drives one request window and records what the DUT did over the access.
  task automatic xfer(input logic [1:0] vm,
                      input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                      output obs_t o);
    o = '0;
    o.gnt = -1;
    bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
    bus.p0_valid = vm[0];
    bus.p1_valid = vm[1];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.p0_ready && bus.p1_ready) o.both_ready = 1'b1;
      if (bus.p0_ready || bus.p1_ready) begin
        o.gnt = bus.p1_ready ? 1 : 0;
        o.wait_cyc = c;
      end
      @(posedge clk); #1;
      if (o.gnt >= 0) break;
    end
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    bus.p0_addr = $urandom; bus.p0_wdata = $urandom; bus.p0_we = 1'($urandom);
    bus.p1_addr = $urandom; bus.p1_wdata = $urandom; bus.p1_we = 1'($urandom);
    if (o.gnt < 0) return;
    @(negedge clk);
    o.mw1 = bus.mem_write;
    o.maddr1 = bus.m_addr;
    o.mwdata1 = bus.m_w_data;
    o.busy_ready = bus.p0_ready | bus.p1_ready;
    o.rv_early = bus.p0_resp_valid | bus.p1_resp_valid;
    @(posedge clk); #1;
    @(negedge clk);
    o.mw2 = bus.mem_write;
    o.busy_ready = o.busy_ready | bus.p0_ready | bus.p1_ready;
    if (o.gnt == 1) begin
      o.rv = bus.p1_resp_valid; o.rdata = bus.p1_resp_rdata;
      o.err = bus.p1_resp_err;  o.rv_other = bus.p0_resp_valid;
    end else begin
      o.rv = bus.p0_resp_valid; o.rdata = bus.p0_resp_rdata;
      o.err = bus.p0_resp_err;  o.rv_other = bus.p1_resp_valid;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_clr = 1'b1;
    bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
    bus.p0_we = 1'b0; bus.p1_we = 1'b1;
    bus.p0_addr = 32'd3; bus.p1_addr = 32'd4;
    bus.p0_wdata = 32'h1; bus.p1_wdata = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b00) begin failures++;
      $display("FAIL reset_ready got=%b exp=00", {bus.p0_ready, bus.p1_ready}); end
    checks++; if (bus.mem_write !== 1'b0) begin failures++;
      $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
    checks++; if ({bus.p0_resp_valid, bus.p1_resp_valid, bus.p0_resp_err, bus.p1_resp_err} !== 4'b0) begin
      failures++; $display("FAIL reset_resp got=%b exp=0000",
        {bus.p0_resp_valid, bus.p1_resp_valid, bus.p0_resp_err, bus.p1_resp_err}); end
    checks++; if ({bus.m_addr, bus.m_w_data, bus.p0_resp_rdata, bus.p1_resp_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.m_addr, bus.m_w_data,
        bus.p0_resp_rdata, bus.p1_resp_rdata); end
    @(posedge clk); #1;
    mem_clr = 1'b0;
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    rst = 1'b1;
    ref_prio = 0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    obs_t o;
    preload(5, 32'hDEAD_BEEF);
    xfer(2'b01, 1'b0, 32'd5, 32'h0, 1'b0, 32'd0, 32'h0, o);
    checks++; if (o.gnt !== 0 || o.wait_cyc !== 0) begin failures++;
      $display("FAIL rd_grant got=%0d@%0d exp=0@0", o.gnt, o.wait_cyc); end
    checks++; if (o.mw1 !== 1'b0 || o.mw2 !== 1'b0) begin failures++;
      $display("FAIL rd_mem_write got=%b%b exp=00", o.mw1, o.mw2); end
    checks++; if (o.maddr1 !== 32'd5) begin failures++;
      $display("FAIL rd_m_addr got=%0d exp=5", o.maddr1); end
    checks++; if (o.rv !== 1'b1 || o.rv_early !== 1'b0 || o.rv_other !== 1'b0) begin failures++;
      $display("FAIL rd_resp_timing got=rv%b early%b other%b exp=rv1 early0 other0",
        o.rv, o.rv_early, o.rv_other); end
    checks++; if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin failures++;
      $display("FAIL rd_data got=%h err%b exp=deadbeef err0", o.rdata, o.err); end
    model_commit(0, 1'b0, 32'd5, 32'h0);
  endtask

  task automatic test_write_then_read();
    obs_t o;
    xfer(2'b10, 1'b0, 32'd0, 32'h0, 1'b1, 32'd127, 32'h1234_5678, o);
    checks++; if (o.gnt !== 1) begin failures++;
      $display("FAIL wr_grant got=%0d exp=1", o.gnt); end
    checks++; if (o.mw1 !== 1'b1 || o.mw2 !== 1'b0) begin failures++;
      $display("FAIL wr_mem_write got=%b%b exp=10", o.mw1, o.mw2); end
    checks++; if (o.maddr1 !== 32'd127 || o.mwdata1 !== 32'h1234_5678) begin failures++;
      $display("FAIL wr_bus got=%0d/%h exp=127/12345678", o.maddr1, o.mwdata1); end
    checks++; if (o.rv !== 1'b1 || o.rdata !== 32'h0 || o.err !== 1'b0) begin failures++;
      $display("FAIL wr_ack got=rv%b %h err%b exp=rv1 0 err0", o.rv, o.rdata, o.err); end
    model_commit(1, 1'b1, 32'd127, 32'h1234_5678);
    xfer(2'b01, 1'b0, 32'd127, 32'h0, 1'b0, 32'd0, 32'h0, o);
    checks++; if (o.rv !== 1'b1 || o.rdata !== 32'h1234_5678) begin failures++;
      $display("FAIL raw_data got=rv%b %h exp=rv1 12345678", o.rv, o.rdata); end
    model_commit(0, 1'b0, 32'd127, 32'h0);
  endtask

  task automatic test_contention();
    int gq[$];
    int cq[$];
    int nresp[2];
    int first;
    int g;
    logic both;
    first = ref_prio;
    both = 1'b0;
    nresp[0] = 0; nresp[1] = 0;
    bus.p0_we = 1'b0; bus.p0_addr = 32'd5;   bus.p0_wdata = $urandom;
    bus.p1_we = 1'b0; bus.p1_addr = 32'd127; bus.p1_wdata = $urandom;
    bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.p0_ready && bus.p1_ready) both = 1'b1;
      if (bus.p0_resp_valid) begin
        nresp[0]++;
        checks++; if (bus.p0_resp_rdata !== ref_mem[5]) begin failures++;
          $display("FAIL cont_p0_data got=%h exp=%h", bus.p0_resp_rdata, ref_mem[5]); end
      end
      if (bus.p1_resp_valid) begin
        nresp[1]++;
        checks++; if (bus.p1_resp_rdata !== ref_mem[127]) begin failures++;
          $display("FAIL cont_p1_data got=%h exp=%h", bus.p1_resp_rdata, ref_mem[127]); end
      end
      g = bus.p0_ready ? 0 : (bus.p1_ready ? 1 : -1);
      if (g >= 0) begin gq.push_back(g); cq.push_back(c); end
      @(posedge clk); #1;
      if (g == 0) bus.p0_wdata = $urandom;
      if (g == 1) bus.p1_wdata = $urandom;
    end
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    checks++; if (gq.size() !== 4) begin failures++;
      $display("FAIL cont_grant_count got=%0d exp=4", gq.size()); end
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      checks++; if (gq[i] !== (first + i) % 2 || cq[i] !== 3 * i) begin failures++;
        $display("FAIL cont_grant%0d got=p%0d@%0d exp=p%0d@%0d", i, gq[i], cq[i], (first + i) % 2, 3 * i); end
    end
    checks++; if (both !== 1'b0) begin failures++;
      $display("FAIL cont_both_ready got=%b exp=0", both); end
    checks++; if (nresp[0] !== 2 || nresp[1] !== 2) begin failures++;
      $display("FAIL cont_resp_count got=%0d/%0d exp=2/2", nresp[0], nresp[1]); end
    // Four alternating grants leave priority where it started.
    ref_prio = first;
  endtask

  task automatic test_out_of_range();
    obs_t o;
    preload(0, 32'hA5A5_0001);
    xfer(2'b10, 1'b0, 32'd0, 32'h0, 1'b1, 32'd128, 32'hCAFE_F00D, o);
    checks++; if (o.gnt !== 1 || o.mw1 !== 1'b0 || o.mw2 !== 1'b0) begin failures++;
      $display("FAIL oob_write got=gnt%0d mw%b%b exp=gnt1 mw00", o.gnt, o.mw1, o.mw2); end
    checks++; if (o.maddr1 !== 32'd0) begin failures++;
      $display("FAIL oob_m_addr got=%0d exp=0", o.maddr1); end
    checks++; if (o.rv !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin failures++;
      $display("FAIL oob_resp got=rv%b err%b %h exp=rv1 err1 0", o.rv, o.err, o.rdata); end
    checks++; if (mem[0] !== 32'hA5A5_0001) begin failures++;
      $display("FAIL oob_mem0 got=%h exp=a5a50001", mem[0]); end
    model_commit(1, 1'b1, 32'd128, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_op();
    preload(10, 32'h0BAD_F00D);
    bus.p0_we = 1'b1; bus.p0_addr = 32'd10; bus.p0_wdata = 32'h1111_2222;
    bus.p0_valid = 1'b1; bus.p1_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.p0_ready !== 1'b1) begin failures++;
      $display("FAIL rmo_grant got=%b exp=1", bus.p0_ready); end
    @(posedge clk); #1;
    bus.p0_valid = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b1) begin failures++;
      $display("FAIL rmo_access got=%b exp=1", bus.mem_write); end
    bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
    bus.p1_we = 1'b0; bus.p1_addr = 32'd5;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b0 || {bus.p0_ready, bus.p1_ready} !== 2'b00 || bus.m_addr !== 32'd0) begin
      failures++; $display("FAIL rmo_async got=mw%b rdy%b%b addr%0d exp=mw0 rdy00 addr0",
        bus.mem_write, bus.p0_ready, bus.p1_ready, bus.m_addr); end
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({bus.p0_resp_valid, bus.p1_resp_valid} !== 2'b00) begin failures++;
      $display("FAIL rmo_no_resp got=%b%b exp=00", bus.p0_resp_valid, bus.p1_resp_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    ref_prio = 0;
    @(negedge clk);
    checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin failures++;
      $display("FAIL rmo_prio got=p0%b p1%b exp=p0 1 p1 0", bus.p0_ready, bus.p1_ready); end
    #1;
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[10] !== 32'h0BAD_F00D && mem[10] !== 32'h1111_2222) begin failures++;
      $display("FAIL rmo_target got=%h exp=0badf00d or 11112222", mem[10]); end
    if (mem[10] === 32'h1111_2222) ref_mem[10] = 32'h1111_2222;
  endtask

  task automatic test_lone_requester();
    obs_t o;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ref_prio = 0;
    @(posedge clk); #1;
    xfer(2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 32'd5, 32'h0, o);
    checks++; if (o.gnt !== 1 || o.wait_cyc !== 0) begin failures++;
      $display("FAIL lone_grant got=p%0d@%0d exp=p1@0", o.gnt, o.wait_cyc); end
    checks++; if (o.rdata !== exp_rdata(1'b0, 32'd5)) begin failures++;
      $display("FAIL lone_data got=%h exp=%h", o.rdata, exp_rdata(1'b0, 32'd5)); end
    model_commit(1, 1'b0, 32'd5, 32'h0);
    xfer(2'b11, 1'b0, 32'd127, 32'h0, 1'b0, 32'd5, 32'h0, o);
    checks++; if (o.gnt !== 0 || o.both_ready !== 1'b0) begin failures++;
      $display("FAIL lone_next_tie got=p%0d both%b exp=p0 both0", o.gnt, o.both_ready); end
    checks++; if (o.rdata !== exp_rdata(1'b0, 32'd127)) begin failures++;
      $display("FAIL lone_tie_data got=%h exp=%h", o.rdata, exp_rdata(1'b0, 32'd127)); end
    model_commit(0, 1'b0, 32'd127, 32'h0);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return 32'($urandom_range(0, 15));
    if (r == 7) return 32'($urandom_range(120, 135));
    if (r == 8) return ($urandom_range(0, 1) != 0) ? 32'd127 : 32'd128;
    return $urandom | 32'h8000_0000;
  endfunction

  task automatic test_random();
    obs_t        o;
    logic [1:0]  vm;
    logic        we [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    int          eg;
    logic        e_err;
    logic        e_mw;
    logic [31:0] e_rd;
    for (int n = 0; n < 40; n++) begin
      vm = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        a[p]  = pick_addr();
        d[p]  = $urandom;
      end
      eg    = exp_gnt(vm);
      e_err = a[eg] >= 32'd128;
      e_mw  = we[eg] && !e_err;
      e_rd  = exp_rdata(we[eg], a[eg]);
      xfer(vm, we[0], a[0], d[0], we[1], a[1], d[1], o);
      checks++; if (o.gnt !== eg || o.wait_cyc !== 0 || o.both_ready !== 1'b0) begin failures++;
        $display("FAIL rnd%0d_grant got=p%0d@%0d both%b exp=p%0d@0 both0", n, o.gnt, o.wait_cyc, o.both_ready, eg); end
      checks++; if (o.mw1 !== e_mw || o.mw2 !== 1'b0) begin failures++;
        $display("FAIL rnd%0d_mem_write got=%b%b exp=%b0", n, o.mw1, o.mw2, e_mw); end
      checks++; if (o.maddr1 !== (e_err ? 32'd0 : a[eg]) || (e_mw && o.mwdata1 !== d[eg])) begin failures++;
        $display("FAIL rnd%0d_bus got=%h/%h exp=%h/%h", n, o.maddr1, o.mwdata1, e_err ? 32'd0 : a[eg], d[eg]); end
      checks++; if (o.rv !== 1'b1 || o.rv_early !== 1'b0 || o.rv_other !== 1'b0 || o.busy_ready !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_timing got=rv%b early%b other%b busy%b exp=1000",
          n, o.rv, o.rv_early, o.rv_other, o.busy_ready); end
      checks++; if (o.rdata !== e_rd || o.err !== e_err) begin failures++;
        $display("FAIL rnd%0d_resp got=%h err%b exp=%h err%b", n, o.rdata, o.err, e_rd, e_err); end
      model_commit(eg, we[eg], a[eg], d[eg]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    bus.p0_we = 1'b0; bus.p1_we = 1'b0;
    bus.p0_addr = '0; bus.p1_addr = '0;
    bus.p0_wdata = '0; bus.p1_wdata = '0;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_out_of_range();
    test_reset_mid_op();
    test_lone_requester();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
